// File: rtl/pipe_ctrl.sv
// Pipeline hazard / redirect controller: load-use stall, branch/jump/exception flush, MDU stall.
// Optional multi-cycle MDU stall support is compiled in with `define PIPE_CTRL_MDU_EN.
module pipe_ctrl #(
  parameter int MDU_LAT = 32
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [4:0] IfId_Rs,
  input  logic [4:0] IfId_Rt,
  input  logic       IdEx_MemtoReg,
  input  logic [4:0] IdEx_Rd,
  input  logic       MulDiv_start,
  input  logic       Jump_mem,
  input  logic       Zero_mem,
  input  logic       Less_mem,
  input  logic       Exception_mem,
  input  logic [2:0] Condition_mem,
  output logic       PC_Write,
  output logic       IfId_Stall,
  output logic       IfId_Flush,
  output logic       IdEx_Stall,
  output logic       IdEx_Flush,
  output logic       ExMem_Flush,
  output logic [1:0] PCSrc,
  output logic       Busy,
  output logic       Mdu_Abort
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] EXC_DRAIN = 2'd2;
`ifdef PIPE_CTRL_MDU_EN
  localparam logic [1:0] MDU_WAIT  = 2'd1;
  localparam logic [5:0] LAT_M1    = 6'(MDU_LAT - 1);
`endif

  if (MDU_LAT < 2 || MDU_LAT > 63) begin : g_lat_check
    $error("pipe_ctrl: MDU_LAT must be within 2..63");
  end

  logic [1:0] state_reg, state_next;
  logic       tk;
  logic       redirect;
  logic       load_use;
  logic       in_mdu;

  logic       if_id_stall_raw, id_ex_stall_raw;
  logic       if_id_flush_raw, id_ex_flush_raw;

  always_comb begin
    tk = 1'b0;
    case (Condition_mem)
      3'b001:  tk = Zero_mem;
      3'b010:  tk = ~Zero_mem;
      3'b011:  tk = Less_mem;
      3'b100:  tk = ~Less_mem;
      3'b101:  tk = Less_mem | Zero_mem;
      3'b110:  tk = ~Less_mem & ~Zero_mem;
      default: tk = 1'b0;
    endcase
  end

  assign redirect = Exception_mem | Jump_mem | tk;
  assign load_use = IdEx_MemtoReg && (IdEx_Rd != 5'd0) &&
                    ((IdEx_Rd == IfId_Rs) || (IdEx_Rd == IfId_Rt));

`ifdef PIPE_CTRL_MDU_EN
  logic [5:0] cnt_reg, cnt_next;
  assign in_mdu = (state_reg == MDU_WAIT);
`else
  logic mdu_unused;
  assign mdu_unused = MulDiv_start;
  assign in_mdu     = 1'b0;
`endif

  // Output decode: a single priority chain keeps the responses mutually exclusive.
  always_comb begin
    PC_Write        = 1'b1;
    PCSrc           = 2'd0;
    if_id_stall_raw = 1'b0;
    id_ex_stall_raw = 1'b0;
    if_id_flush_raw = 1'b0;
    id_ex_flush_raw = 1'b0;
    ExMem_Flush     = 1'b0;
    Busy            = 1'b0;
    Mdu_Abort       = 1'b0;
    if (Reset) begin
      if_id_flush_raw = 1'b1;
      id_ex_flush_raw = 1'b1;
      ExMem_Flush     = 1'b1;
    end else if (redirect) begin
      if (Exception_mem)
        PCSrc = 2'd3;
      else if (Jump_mem)
        PCSrc = 2'd2;
      else
        PCSrc = 2'd1;
      if_id_flush_raw = 1'b1;
      id_ex_flush_raw = 1'b1;
      ExMem_Flush     = 1'b1;
      Mdu_Abort       = in_mdu;
    end else if (state_reg == EXC_DRAIN) begin
      if_id_flush_raw = 1'b1;
    end else if (in_mdu) begin
      Busy            = 1'b1;
      PC_Write        = 1'b0;
      if_id_stall_raw = 1'b1;
      id_ex_stall_raw = 1'b1;
      ExMem_Flush     = 1'b1;
    end else if (load_use) begin
      PC_Write        = 1'b0;
      if_id_stall_raw = 1'b1;
      id_ex_flush_raw = 1'b1;
    end
  end

  // Clearing a register always overrides holding it.
  assign IfId_Flush = if_id_flush_raw;
  assign IdEx_Flush = id_ex_flush_raw;
  assign IfId_Stall = if_id_stall_raw & ~if_id_flush_raw;
  assign IdEx_Stall = id_ex_stall_raw & ~id_ex_flush_raw;

  always_comb begin
    state_next = state_reg;
`ifdef PIPE_CTRL_MDU_EN
    cnt_next   = cnt_reg;
`endif
    if (Exception_mem) begin
      state_next = EXC_DRAIN;
`ifdef PIPE_CTRL_MDU_EN
      cnt_next   = 6'd0;
`endif
    end else if (redirect) begin
      state_next = RUN;
`ifdef PIPE_CTRL_MDU_EN
      cnt_next   = 6'd0;
`endif
    end else begin
      case (state_reg)
        EXC_DRAIN: state_next = RUN;
`ifdef PIPE_CTRL_MDU_EN
        MDU_WAIT: begin
          if (cnt_reg == 6'd0)
            state_next = RUN;
          else
            cnt_next = cnt_reg - 6'd1;
        end
        RUN: begin
          if (MulDiv_start) begin
            state_next = MDU_WAIT;
            cnt_next   = LAT_M1;
          end
        end
`endif
        default: state_next = RUN;
      endcase
    end
  end

  // State advances on the falling edge, in step with the pipeline registers.
  always_ff @(negedge clk) begin
    if (Reset) begin
      state_reg <= RUN;
`ifdef PIPE_CTRL_MDU_EN
      cnt_reg   <= 6'd0;
`endif
    end else begin
      state_reg <= state_next;
`ifdef PIPE_CTRL_MDU_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: behavioural reference model checked every cycle plus literal directed checks.
module tb_pipe_ctrl;

  localparam int LAT = 4;
`ifdef PIPE_CTRL_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  // Output vector: {PC_Write, IfId_Stall, IfId_Flush, IdEx_Stall, IdEx_Flush, ExMem_Flush, PCSrc, Busy, Mdu_Abort}
  localparam logic [9:0] V_NORM  = 10'b1000000000;
  localparam logic [9:0] V_LU    = 10'b0100100000;
  localparam logic [9:0] V_BR    = 10'b1010110100;
  localparam logic [9:0] V_JMP   = 10'b1010111000;
  localparam logic [9:0] V_EXC   = 10'b1010111100;
  localparam logic [9:0] V_DRAIN = 10'b1010000000;
  localparam logic [9:0] V_RST   = 10'b1010110000;
`ifdef PIPE_CTRL_MDU_EN
  localparam logic [9:0] V_MDU   = 10'b0101010010;
  localparam logic [9:0] V_EXC_A = 10'b1010111101;
  localparam logic [9:0] V_BR_A  = 10'b1010110101;
`endif

  logic       clk = 1'b0;
  logic       Reset;
  logic [4:0] IfId_Rs, IfId_Rt, IdEx_Rd;
  logic       IdEx_MemtoReg, MulDiv_start, Jump_mem, Zero_mem, Less_mem, Exception_mem;
  logic [2:0] Condition_mem;
  logic       PC_Write, IfId_Stall, IfId_Flush, IdEx_Stall, IdEx_Flush, ExMem_Flush, Busy, Mdu_Abort;
  logic [1:0] PCSrc;
  logic [9:0] outs;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  chk_en = 1'b0;
  int  m_left = 0;
  bit  m_drain = 1'b0;

  pipe_ctrl #(.MDU_LAT(LAT)) dut (
    .clk(clk), .Reset(Reset), .IfId_Rs(IfId_Rs), .IfId_Rt(IfId_Rt),
    .IdEx_MemtoReg(IdEx_MemtoReg), .IdEx_Rd(IdEx_Rd), .MulDiv_start(MulDiv_start),
    .Jump_mem(Jump_mem), .Zero_mem(Zero_mem), .Less_mem(Less_mem),
    .Exception_mem(Exception_mem), .Condition_mem(Condition_mem),
    .PC_Write(PC_Write), .IfId_Stall(IfId_Stall), .IfId_Flush(IfId_Flush),
    .IdEx_Stall(IdEx_Stall), .IdEx_Flush(IdEx_Flush), .ExMem_Flush(ExMem_Flush),
    .PCSrc(PCSrc), .Busy(Busy), .Mdu_Abort(Mdu_Abort)
  );

  assign outs = {PC_Write, IfId_Stall, IfId_Flush, IdEx_Stall, IdEx_Flush, ExMem_Flush, PCSrc, Busy, Mdu_Abort};

  always #5 clk = ~clk;

  function automatic bit model_tk();
    case (Condition_mem)
      3'd1: return Zero_mem;
      3'd2: return !Zero_mem;
      3'd3: return Less_mem;
      3'd4: return !Less_mem;
      3'd5: return Less_mem || Zero_mem;
      3'd6: return !Less_mem && !Zero_mem;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs straight from the priority rules, using "stall cycles left" as the MDU view.
  function automatic logic [9:0] model_exp();
    logic abort;
    abort = (m_left > 0);
    if (Reset) return V_RST;
    if (Exception_mem) return V_EXC | {9'b0, abort};
    if (Jump_mem) return V_JMP | {9'b0, abort};
    if (model_tk()) return V_BR | {9'b0, abort};
    if (m_drain) return V_DRAIN;
    if (m_left > 0) return 10'b0101010010;
    if (IdEx_MemtoReg && IdEx_Rd != 0 && (IdEx_Rd == IfId_Rs || IdEx_Rd == IfId_Rt)) return V_LU;
    return V_NORM;
  endfunction

  always @(posedge clk) begin
    logic [9:0] exp_v;
    cyc++;
    if (chk_en) begin
      exp_v = model_exp();
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL model cycle %0d: outputs %b, expected %b", cyc, outs, exp_v);
      end
    end
  end

  always @(negedge clk) begin
    if (Reset) begin
      m_left = 0; m_drain = 1'b0;
    end else if (Exception_mem) begin
      m_left = 0; m_drain = 1'b1;
    end else if (Jump_mem || model_tk()) begin
      m_left = 0; m_drain = 1'b0;
    end else if (m_drain) begin
      m_drain = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (MDU_EN && MulDiv_start) begin
      m_left = LAT;
    end
  end

  task automatic idle();
    Reset = 1'b0; IfId_Rs = 5'd1; IfId_Rt = 5'd2; IdEx_MemtoReg = 1'b0; IdEx_Rd = 5'd3;
    MulDiv_start = 1'b0; Jump_mem = 1'b0; Zero_mem = 1'b0; Less_mem = 1'b0;
    Exception_mem = 1'b0; Condition_mem = 3'd0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    IdEx_MemtoReg = 1'b1; IdEx_Rd = rd; IfId_Rt = rd;
  endtask

  // One cycle: optional literal check mid-cycle, then advance past the falling edge.
  task automatic tick(input string name, input logic [9:0] lit, input bit use_lit);
    @(posedge clk); #1;
    $display("txn %-12s cycle %0d outputs %b", name, cyc, outs);
    if (use_lit) begin
      checks++;
      if (outs !== lit) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", name, outs, lit);
      end
    end
    @(negedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    chk_en = 1'b1;
    tick("reset0", V_RST, 1);
    Reset = 1'b1;
    tick("reset1", V_RST, 1);
    tick("idle", V_NORM, 1);

    set_lu(5'd5);                                  tick("lu_rt", V_LU, 1);
    tick("lu_after", V_NORM, 1);
    IdEx_MemtoReg = 1'b1; IdEx_Rd = 5'd7; IfId_Rs = 5'd7; tick("lu_rs", V_LU, 1);
    set_lu(5'd0);                                  tick("lu_rd0", V_NORM, 1);
    set_lu(5'd9); IdEx_MemtoReg = 1'b0;            tick("lu_nomem", V_NORM, 1);

    Condition_mem = 3'b010; Zero_mem = 1'b0;       tick("bne_taken", V_BR, 1);
    tick("br_after", V_NORM, 1);
    Condition_mem = 3'b010; Zero_mem = 1'b1;       tick("bne_not", V_NORM, 1);

    for (int c = 0; c < 8; c++) begin
      for (int z = 0; z < 4; z++) begin
        set_lu(5'd12);
        Condition_mem = 3'(c); Zero_mem = z[0]; Less_mem = z[1];
        tick("cond_sweep", V_NORM, 0);
      end
    end

    Jump_mem = 1'b1; Condition_mem = 3'b001; Zero_mem = 1'b1; set_lu(5'd4);
    tick("jmp_prio", V_JMP, 1);

    Exception_mem = 1'b1; Jump_mem = 1'b1;         tick("exc", V_EXC, 1);
    set_lu(5'd6);                                  tick("drain", V_DRAIN, 1);
    tick("post_drain", V_NORM, 1);
    Exception_mem = 1'b1;                          tick("exc2", V_EXC, 1);
    Reset = 1'b1;                                  tick("rst_drain", V_RST, 1);
    tick("after_rst", V_NORM, 1);

`ifdef PIPE_CTRL_MDU_EN
    MulDiv_start = 1'b1;                           tick("mdu_start", V_NORM, 1);
    for (int i = 0; i < LAT; i++) begin
      MulDiv_start = 1'b1;                         tick("mdu_wait", V_MDU, 1);
    end
    tick("mdu_done", V_NORM, 1);

    MulDiv_start = 1'b1;                           tick("mdu_start2", V_NORM, 1);
    tick("mdu_c1", V_MDU, 1);
    Exception_mem = 1'b1;                          tick("mdu_exc", V_EXC_A, 1);
    tick("mdu_drain", V_DRAIN, 1);
    tick("mdu_run", V_NORM, 1);

    MulDiv_start = 1'b1;                           tick("mdu_start3", V_NORM, 1);
    set_lu(5'd8);                                  tick("mdu_lu", V_MDU, 1);
    Condition_mem = 3'b001; Zero_mem = 1'b1;       tick("mdu_br", V_BR_A, 1);
    tick("mdu_br_run", V_NORM, 1);

    MulDiv_start = 1'b1;                           tick("mdu_start4", V_NORM, 1);
    tick("mdu_w1", V_MDU, 1);
    Reset = 1'b1;                                  tick("mdu_rst", V_RST, 1);
    tick("mdu_rst_run", V_NORM, 1);
`else
    MulDiv_start = 1'b1;                           tick("mdu_off", V_NORM, 1);
    tick("mdu_off1", V_NORM, 1);
    MulDiv_start = 1'b1; set_lu(5'd3);             tick("mdu_off_lu", V_LU, 1);
    tick("mdu_off2", V_NORM, 1);
`endif

    for (int i = 0; i < 3; i++) tick("tail", V_NORM, 1);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
